// File: rtl/pc_ras.sv
// Fetch PC with relative branch, absolute jump and call/return through a circular return-address stack.
// pc updates one cycle after a strobe is sampled; stall freezes pc and the stack and masks every other strobe.
module pc_ras #(
  parameter int              WIDTH     = 8,
  parameter int              INC       = 1,
  parameter int              DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             branch_en,
  input  logic             jump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] target,
  output logic [WIDTH-1:0] pc,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    top_q, top_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             run_q, run_d;
  logic [WIDTH-1:0] ras_q [DEPTH];

  logic             push_we;
  logic [PW-1:0]    push_idx;
  logic [WIDTH-1:0] pc_inc;

  assign pc_inc   = pc_q + INC_W;
  assign push_idx = top_q + PW'(1);
  // The first edge after reset release only arms run_q; updates start on the next edge.
  assign run_d    = 1'b1;

  always_comb begin
    pc_d    = pc_inc;
    top_d   = top_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    push_we = 1'b0;
    if (!run_q || stall) begin
      pc_d = pc_q;
    end else if (ret_en) begin
      if (cnt_q != '0) begin
        pc_d  = ras_q[top_q];
        top_d = top_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end else begin
        err_d = 1'b1;
      end
    end else if (call_en) begin
      // When full the slot above top is the oldest entry, so the push overwrites it.
      push_we = 1'b1;
      top_d   = push_idx;
      pc_d    = target;
      if (cnt_q == FULL_CNT) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else if (jump_en) begin
      pc_d = target;
    end else if (branch_en) begin
      pc_d = pc_q + immediate;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VEC;
      top_q <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
      run_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      top_q <= top_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
      run_q <= run_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_we) begin
      ras_q[push_idx] <= pc_inc;
    end
  end

  assign pc        = pc_q;
  assign ras_empty = (cnt_q == '0);
  assign ras_full  = (cnt_q == FULL_CNT);
  assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_ras.sv
// Directed vector bench for pc_ras at default parameters (WIDTH=8, INC=1, DEPTH=4, RESET_VEC=0).
module tb_pc_ras;

  logic       clk;
  logic       reset;
  logic       stall, branch_en, jump_en, call_en, ret_en;
  logic [7:0] immediate, target;
  logic [7:0] pc;
  logic       ras_empty, ras_full, ras_err;

  int total = 0;
  int bad   = 0;

  pc_ras dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .branch_en (branch_en),
    .jump_en   (jump_en),
    .call_en   (call_en),
    .ret_en    (ret_en),
    .immediate (immediate),
    .target    (target),
    .pc        (pc),
    .ras_empty (ras_empty),
    .ras_full  (ras_full),
    .ras_err   (ras_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       st, br, jp, ca, re;
    logic [7:0] imm, tgt;
    logic [7:0] exp_pc;
    logic       exp_empty, exp_full, exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic st, br, jp, ca, re, input logic [7:0] imm, tgt,
                     input logic [7:0] epc, input logic ee, ef, er);
    vec_t v;
    v.st = st; v.br = br; v.jp = jp; v.ca = ca; v.re = re;
    v.imm = imm; v.tgt = tgt; v.exp_pc = epc;
    v.exp_empty = ee; v.exp_full = ef; v.exp_err = er;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] epc, input logic ee, ef, er);
    chk({tag, " pc"}, pc, epc);
    chk({tag, " empty"}, {7'd0, ras_empty}, {7'd0, ee});
    chk({tag, " full"}, {7'd0, ras_full}, {7'd0, ef});
    chk({tag, " err"}, {7'd0, ras_err}, {7'd0, er});
  endtask

  task automatic drive(input logic st, br, jp, ca, re, input logic [7:0] imm, tgt);
    stall = st; branch_en = br; jump_en = jp; call_en = ca; ret_en = re;
    immediate = imm; target = tgt;
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      drive(vq[i].st, vq[i].br, vq[i].jp, vq[i].ca, vq[i].re, vq[i].imm, vq[i].tgt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vq[i].exp_pc, vq[i].exp_empty, vq[i].exp_full, vq[i].exp_err);
    end
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  int part_a;

  initial begin
    //  st br jp ca re imm    tgt    pc     e  f  r
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h01, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h02, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h03, 1, 0, 0);
    add(0, 1, 0, 0, 0, 8'hFE, 8'h00, 8'h01, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'hFE, 8'hFE, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'hFF, 1, 0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h10, 8'h10, 1, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h40, 8'h40, 0, 0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h41, 0, 0, 0);
    add(0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h42, 0, 0, 0);
    add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h11, 1, 0, 0);
    add(0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h20, 8'h20, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h30, 8'h30, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h40, 8'h40, 0, 0, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h50, 8'h50, 0, 1, 0);
    add(0, 0, 0, 1, 0, 8'h00, 8'h60, 8'h60, 0, 1, 1);
    add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h51, 0, 0, 1);
    add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h41, 0, 0, 1);
    add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h31, 0, 0, 1);
    add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h21, 1, 0, 1);
    part_a = vq.size();
    // Second run, starting from a fresh reset at pc 0.
    add(0, 0, 1, 0, 0, 8'h00, 8'h08, 8'h08, 1, 0, 0);
    add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h09, 1, 0, 1);
    add(1, 0, 0, 1, 0, 8'h00, 8'h77, 8'h09, 1, 0, 1);
    add(0, 0, 1, 1, 0, 8'h00, 8'h80, 8'h80, 0, 0, 1);
    add(0, 0, 0, 0, 1, 8'h00, 8'h00, 8'h0A, 1, 0, 1);
    add(0, 0, 0, 1, 0, 8'h00, 8'h90, 8'h90, 0, 0, 1);
    add(0, 0, 0, 1, 1, 8'h00, 8'h33, 8'h0B, 1, 0, 1);
    add(0, 1, 1, 0, 0, 8'h05, 8'h20, 8'h20, 1, 0, 1);
    add(0, 1, 0, 0, 0, 8'h05, 8'h00, 8'h25, 1, 0, 1);
    add(1, 1, 0, 0, 0, 8'h05, 8'h00, 8'h25, 1, 0, 1);
    add(0, 0, 0, 1, 0, 8'h00, 8'h50, 8'h50, 0, 0, 1);
    add(0, 0, 0, 1, 0, 8'h00, 8'h60, 8'h60, 0, 0, 1);

    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all("rst0", 8'h00, 1, 0, 0);
    @(posedge clk); #1;
    chk_all("rst1", 8'h00, 1, 0, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("release_edge pc", pc, 8'h00);

    run_vecs(0, part_a);

    // Clean reset between the two runs clears the sticky error.
    reset = 1'b0;
    #1;
    chk_all("rst2", 8'h00, 1, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("release2 pc", pc, 8'h00);

    run_vecs(part_a, vq.size());

    // Asynchronous reset between edges with two entries on the stack.
    #3;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 1, 0, 0);
    @(posedge clk); #1;
    chk("async_hold pc", pc, 8'h00);
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("post_async pc", pc, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach the end, got t=%0t expected < 50000", $time);
    $fatal(1);
  end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised program-counter unit; next generation of the 8-bit increment/branch PC.
- Adds configurable width and increment, a reset vector, stall, absolute jump, and call/return through an internal return-address stack (RAS).
- Sits at the front of the fetch path. It drives the instruction-memory address and takes control strobes from the decoder.

Parameters:
- WIDTH, 8, bit width of PC, immediate, target and RAS entries.
- INC, 1, sequential increment added to PC each cycle.
- DEPTH, 4, number of RAS entries (power of two, >= 2).
- RESET_VEC, 0, PC value loaded on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hold PC and RAS; all other strobes ignored.
- branch_en  input  1  relative branch: PC <= PC + immediate.
- jump_en  input  1  absolute jump: PC <= target.
- call_en  input  1  push PC+INC to the RAS, then PC <= target.
- ret_en  input  1  pop the RAS into PC.
- immediate  input  WIDTH  two's-complement branch offset.
- target  input  WIDTH  absolute jump/call address.
- pc  output  WIDTH  current program counter (registered).
- ras_empty  output  1  RAS holds 0 entries (combinational from count).
- ras_full  output  1  RAS holds DEPTH entries (combinational from count).
- ras_err  output  1  sticky overflow/underflow flag.

Behaviour:
- Reset (reset low, asynchronous, immediate on assertion, including mid-operation):
  - pc = RESET_VEC, RAS count = 0, ras_err = 0.
  - So ras_empty = 1 and ras_full = 0.
  - RAS entry contents are don't-care.
  - Deassertion is sampled at the next rising clk; the first update occurs on the following edge.
- All state updates on rising clk; pc reflects the selected operation one cycle after the strobe is sampled (latency 1).
- Per-edge priority, exactly one action taken:
  1. stall: hold pc, RAS count, ras_err.
  2. ret_en: pop.
  3. call_en: push.
  4. jump_en: absolute jump.
  5. branch_en: relative branch.
  6. none: pc <= pc + INC.
- Arithmetic: all sums are WIDTH bits, modulo 2^WIDTH. Wrap-around is silent, with no flag.
  - Increment example: 0xFF + 1 = 0x00 at WIDTH=8.
  - Branch example: immediate 0xFE means -2.
- Call:
  - Writes pc+INC (mod 2^WIDTH) to the top-of-stack slot, count += 1, then pc <= target.
- Call when full (count == DEPTH): circular overwrite.
  - The oldest entry is discarded.
  - The new entry becomes top of stack.
  - count stays DEPTH.
  - ras_err set to 1.
- Ret with count > 0:
  - pc <= top entry, count -= 1.
- Ret when empty (underflow):
  - pc <= pc + INC (treated as a no-op sequential step).
  - count stays 0.
  - ras_err set to 1.
- ras_err is sticky and clears only on reset.
- Implementation is a circular buffer with a top pointer of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
- Lower-priority strobes asserted together with a higher one are ignored entirely: no push, no pop, no flag change.

Test Plan:
- Reset and increment: reset low 2 cycles, then high, no strobes -> pc = 0 held during reset, then 1, 2, 3 on successive edges; ras_empty = 1, ras_full = 0, ras_err = 0.
- Branch and wrap: pc = 0x03, branch_en with immediate 0xFE -> pc = 0x01. Free-run from pc = 0xFE -> 0xFF, then 0x00.
- Call/return: pc = 0x10, call_en with target 0x40 -> pc = 0x40, ras_empty = 0. Two idle cycles -> pc = 0x42. ret_en -> pc = 0x11, ras_empty = 1.
- Overflow: 5 calls with no returns, from pc values 0x00, 0x20, 0x30, 0x40, 0x50 (targets 0x20, 0x30, 0x40, 0x50, 0x60) -> ras_full = 1, ras_err = 1. Then 4 returns -> pc = 0x51, 0x41, 0x31, 0x21; ras_empty = 1. Entry 0x01 is lost.
- Underflow and priority: stack empty at pc = 0x08, ret_en -> pc = 0x09, ras_err = 1. Then stall with call_en at pc = 0x09 -> pc stays 0x09 and the RAS is unchanged. Then call_en and jump_en together (target 0x80) -> pc = 0x80 and one entry (0x0A) is pushed.
- Reset mid-operation: after 2 calls, assert reset asynchronously between clock edges -> pc = RESET_VEC immediately, ras_empty = 1, ras_err = 0 without waiting for a clock edge.
